// File: rtl/voice_alloc_if.sv
// rtl/voice_alloc_if.sv - note request channel between a note source and voice_alloc
//
// Purpose: groups the note-on/note-off request handshake into one bundle.
// Signals:
//   req_valid  request present (master -> slave)
//   req_ready  allocator can accept (slave -> master)
//   req_on     1 = note-on, 0 = note-off
//   req_note   note number
//   req_finc   frequency increment for note-on
interface voice_alloc_if #(
  parameter int NOTE_W = 7,
  parameter int FINC_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_on;
  logic [NOTE_W-1:0] req_note;
  logic [FINC_W-1:0] req_finc;

  modport master (output req_valid, req_on, req_note, req_finc, input req_ready);
  modport slave  (input req_valid, req_on, req_note, req_finc, output req_ready);
endinterface

// File: rtl/voice_alloc.sv
// rtl/voice_alloc.sv - polyphonic voice allocator feeding per-voice phase accumulators
//
// Purpose: accepts note-on/note-off requests and assigns each note to one of
// NUM_VOICES oscillator slots. A request is scanned one slot per cycle
// (IDLE -> SCAN x NUM_VOICES -> COMMIT -> IDLE); slot state only changes on
// the edge that ends COMMIT.
// Optional feature macro: VOICE_ALLOC_STEAL_EN
//   defined   - a note-on with no free and no matching slot steals the oldest slot
//   undefined - such a note-on is discarded and drop pulses for one cycle
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req            voice_alloc_if.slave request channel
//   voice_finc     packed per-slot increments, slot i at [i*FINC_W +: FINC_W]
//   voice_active   per-slot sounding flag
//   voice_load     1-cycle per-slot phase restart strobe
//   drop           1-cycle strobe when a note-on is discarded
module voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int FINC_W     = 16,
  parameter int NOTE_W     = 7,
  parameter int AGE_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  voice_alloc_if.slave                 req,
  output logic [NUM_VOICES*FINC_W-1:0] voice_finc,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NUM_VOICES-1:0]        voice_load,
  output logic                         drop
);
  localparam int IDX_W = $clog2(NUM_VOICES);
  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t state_q, state_d;
  idx_t   idx_q;

  // captured request
  logic              on_q;
  logic [NOTE_W-1:0] note_q;
  logic [FINC_W-1:0] finc_q;

  // slot registers
  logic [FINC_W-1:0] finc_r [NUM_VOICES];
  logic [NOTE_W-1:0] note_r [NUM_VOICES];
  logic [AGE_W-1:0]  age_r  [NUM_VOICES];

  // scan results
  logic             match_f, free_f, old_f;
  idx_t             match_i, free_i, old_i;
  logic [AGE_W-1:0] old_age;

  logic accept;
  logic commit_load, commit_clear, commit_drop;
  idx_t tgt;

  assign accept = req.req_valid && req.req_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    req.req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req.req_ready = 1'b1;
        if (req.req_valid) state_d = SCAN;
      end
      SCAN:    if (idx_q == idx_t'(NUM_VOICES - 1)) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Target choice: match > free > oldest (oldest only when stealing is built in).
  always_comb begin
    commit_load  = 1'b0;
    commit_clear = 1'b0;
    commit_drop  = 1'b0;
    tgt          = match_i;
    if (on_q) begin
      if (match_f) begin
        commit_load = 1'b1;
      end else if (free_f) begin
        tgt         = free_i;
        commit_load = 1'b1;
      end else begin
`ifdef VOICE_ALLOC_STEAL_EN
        tgt         = old_i;
        commit_load = 1'b1;
`else
        commit_drop = 1'b1;
`endif
      end
    end else begin
      commit_clear = match_f;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      on_q         <= 1'b0;
      note_q       <= '0;
      finc_q       <= '0;
      match_f      <= 1'b0;
      free_f       <= 1'b0;
      old_f        <= 1'b0;
      match_i      <= '0;
      free_i       <= '0;
      old_i        <= '0;
      old_age      <= '0;
      voice_active <= '0;
      voice_load   <= '0;
      drop         <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        finc_r[i] <= '0;
        note_r[i] <= '0;
        age_r[i]  <= '0;
      end
    end else begin
      voice_load <= '0;
      drop       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            on_q    <= req.req_on;
            note_q  <= req.req_note;
            finc_q  <= req.req_finc;
            idx_q   <= '0;
            match_f <= 1'b0;
            free_f  <= 1'b0;
            old_f   <= 1'b0;
          end
        end
        SCAN: begin
          idx_q <= idx_q + 1'b1;
          if (voice_active[idx_q]) begin
            if (!match_f && note_r[idx_q] == note_q) begin
              match_f <= 1'b1;
              match_i <= idx_q;
            end
            // strict compare keeps the lowest index on equal ages
            if (!old_f || age_r[idx_q] > old_age) begin
              old_f   <= 1'b1;
              old_i   <= idx_q;
              old_age <= age_r[idx_q];
            end
          end else if (!free_f) begin
            free_f <= 1'b1;
            free_i <= idx_q;
          end
        end
        COMMIT: begin
          if (commit_load) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (idx_t'(i) == tgt) begin
                finc_r[i]       <= finc_q;
                note_r[i]       <= note_q;
                age_r[i]        <= '0;
                voice_active[i] <= 1'b1;
                voice_load[i]   <= 1'b1;
              end else if (voice_active[i] && age_r[i] != '1) begin
                age_r[i] <= age_r[i] + 1'b1;
              end
            end
          end
          if (commit_clear) begin
            voice_active[tgt] <= 1'b0;
            finc_r[tgt]       <= '0;
            age_r[tgt]        <= '0;
          end
          drop <= commit_drop;
        end
        default: ;
      endcase
    end
  end

  // Inactive slots hold finc at zero, so the packed bus needs no masking.
  always_comb begin
    voice_finc = '0;
    for (int i = 0; i < NUM_VOICES; i++) voice_finc[i*FINC_W +: FINC_W] = finc_r[i];
  end
endmodule
